// File: rtl/wvb_pkg.sv
// Shared definitions for the waveform buffer read side: header field layout,
// eoe bit position, default widths and the reader FSM state encoding.
package wvb_pkg;
  localparam int DATA_W_DEF    = 28;
  localparam int ADR_W_DEF     = 15;
  localparam int HDR_W_DEF     = 87;
  localparam int HDR_START_LSB = 0;
  localparam int HDR_STOP_LSB  = 15;
  localparam int EOE_BIT       = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    HDR_XFER = 2'd2,
    STREAM   = 2'd3
  } rd_state_e;
endpackage

// File: rtl/wvb_skid_fifo.sv
// Two-entry skid FIFO on the sample return path; head entry drives the
// output directly, so a stalled word stays stable until popped.
module wvb_skid_fifo #(
  parameter int P_WIDTH = 29
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [P_WIDTH-1:0] din,
  input  logic               pop,
  output logic [P_WIDTH-1:0] dout,
  output logic               valid,
  output logic [1:0]         occ
);
  logic [1:0][P_WIDTH-1:0] mem;
  logic                    wp, rp;

  // Upstream never pushes into a full FIFO without a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rp];
  assign valid = (occ != 2'd0);
endmodule

// File: rtl/waveform_buffer_reader.sv
// Pops one header, hands it downstream, then streams the event's samples from
// the waveform BRAM (start..stop, wrapping) through a 2-entry skid FIFO.
module waveform_buffer_reader
  import wvb_pkg::*;
#(
  parameter int P_DATA_WIDTH = DATA_W_DEF,
  parameter int P_ADR_WIDTH  = ADR_W_DEF,
  parameter int P_HDR_WIDTH  = HDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data_out,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data_out,
  output logic [P_HDR_WIDTH-1:0]  hdr_out,
  output logic                    hdr_valid,
  input  logic                    hdr_ready,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    eoe_err
);
  rd_state_e                state, state_nxt;
  logic [P_ADR_WIDTH-1:0]   rd_ptr, stop_addr;
  logic                     stop_issued, inflight, inflight_last;
  logic                     issue, pop, at_stop;
  logic [1:0]               occ;
  logic [2:0]               pending;
  logic [P_DATA_WIDTH:0]    skid_dout;
  logic                     skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en && !hdr_empty) state_nxt = HDR_WAIT;
      HDR_WAIT: state_nxt = HDR_XFER;
      HDR_XFER: if (hdr_ready) state_nxt = STREAM;
      STREAM:   if (pop && dout_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // pop implies occ >= 1, so pending never goes negative.
  always_comb begin
    hdr_rdreq = 1'b0;
    hdr_valid = 1'b0;
    busy      = (state != IDLE);
    pop       = skid_valid & dout_ready;
    pending   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    issue     = 1'b0;
    case (state)
      IDLE:     hdr_rdreq = rst_n & en & ~hdr_empty;
      HDR_XFER: hdr_valid = 1'b1;
      STREAM:   issue     = ~stop_issued & (pending < 3'd2);
      default:  ;
    endcase
  end

  assign at_stop     = (rd_ptr == stop_addr);
  assign wvb_rd_addr = rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_out       <= '0;
      rd_ptr        <= '0;
      stop_addr     <= '0;
      stop_issued   <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      eoe_err       <= 1'b0;
    end else begin
      if (state == HDR_WAIT) begin
        hdr_out     <= hdr_data_out;
        rd_ptr      <= hdr_data_out[HDR_START_LSB +: P_ADR_WIDTH];
        stop_addr   <= hdr_data_out[HDR_STOP_LSB +: P_ADR_WIDTH];
        stop_issued <= 1'b0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (at_stop) stop_issued <= 1'b1;
      end
      inflight      <= issue;
      inflight_last <= issue & at_stop;
      // Stop address owns the last tag; eoe disagreement is only flagged.
      if (inflight && (wvb_data_out[EOE_BIT] != inflight_last)) eoe_err <= 1'b1;
    end
  end

  wvb_skid_fifo #(.P_WIDTH(P_DATA_WIDTH + 1)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   ({inflight_last, wvb_data_out}),
    .pop   (pop),
    .dout  (skid_dout),
    .valid (skid_valid),
    .occ   (occ)
  );

  assign dout       = skid_dout[P_DATA_WIDTH-1:0];
  assign dout_valid = skid_valid;
  assign dout_last  = skid_valid & skid_dout[P_DATA_WIDTH];
endmodule

// File: tb/tb_waveform_buffer_reader.sv
// Scoreboard bench: header FIFO and BRAM models feed the reader; a negedge
// monitor pops expected headers/samples and checks latency and stability.
module tb_waveform_buffer_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        hdr_empty;
  logic [86:0] hdr_data_out = '0;
  logic        hdr_rdreq;
  logic [14:0] wvb_rd_addr;
  logic [27:0] wvb_data_out = '0;
  logic [86:0] hdr_out;
  logic        hdr_valid;
  logic        hdr_ready = 1'b0;
  logic [27:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_last;
  logic        busy;
  logic        eoe_err;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low
  int pushed_n = 0, popped_n = 0;
  logic [86:0] hdr_mem [0:15];
  logic [27:0] bram [0:32767];
  logic [86:0] exp_hdr[$];
  logic [28:0] exp_dat[$];

  waveform_buffer_reader dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hdr_empty(hdr_empty),
    .hdr_data_out(hdr_data_out), .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr),
    .wvb_data_out(wvb_data_out), .hdr_out(hdr_out), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .eoe_err(eoe_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign hdr_empty = (pushed_n == popped_n);
  always @(posedge clk) begin
    if (hdr_rdreq) begin
      hdr_data_out <= hdr_mem[popped_n[3:0]];
      popped_n     <= popped_n + 1;
    end
    wvb_data_out <= bram[wvb_rd_addr];
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) dout_ready = 1'($urandom_range(0, 1));
    else               dout_ready = (rdy_mode == 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [27:0] mkword(input logic [14:0] a, input logic e);
    return {a, 12'h5A3, e};
  endfunction

  // eoe_idx < 0 puts eoe on the final word; otherwise only on that word index.
  task automatic load_event(input logic [14:0] start, input logic [14:0] stop,
                            input int eoe_idx, input int tag);
    logic [14:0] a, span;
    logic [86:0] h;
    logic        e;
    int          n;
    span = stop - start;
    n = int'(span) + 1;
    a = start;
    for (int i = 0; i < n; i++) begin
      e = (eoe_idx < 0) ? (i == n - 1) : (i == eoe_idx);
      bram[a] = mkword(a, e);
      exp_dat.push_back({(i == n - 1), mkword(a, e)});
      a = a + 15'd1;
    end
    h = {57'(64'h1_2345_0000 + 64'(tag)), stop, start};
    hdr_mem[pushed_n[3:0]] = h;
    exp_hdr.push_back(h);
    pushed_n = pushed_n + 1;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((exp_dat.size() != 0 || exp_hdr.size() != 0 || busy) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done"}, (k < 600), 1'b1);
  endtask

  // Monitor state
  int          rdreq_cyc = 0, hs_cyc = 0, last_pop_cyc = -100;
  int          ev_pops = 0, ev_first_cyc = 0, ev_last_cyc = 0;
  logic        first_pending = 1'b0, hv_q = 1'b0, held_vld = 1'b0, hheld_vld = 1'b0;
  logic [28:0] held;
  logic [86:0] hheld;
  logic [28:0] got, ex;

  always @(negedge clk) begin
    if (!rst_n) begin
      first_pending = 1'b0; hv_q = 1'b0; held_vld = 1'b0; hheld_vld = 1'b0;
    end else begin
      if (hdr_rdreq) begin
        rdreq_cyc = cyc;
        chk("rdreq_nonempty", hdr_empty, 1'b0);
      end
      if (hdr_valid && !hv_q) begin
        chk("hdr_latency", cyc - rdreq_cyc, 2);
        chk("event_gap_ge3", (cyc - last_pop_cyc) >= 3, 1'b1);
      end
      if (hdr_valid && hheld_vld) chk("hdr_stable", hdr_out, hheld);
      if (hdr_valid && hdr_ready) begin
        if (exp_hdr.size() == 0) chk("hdr_unexpected", 1'b1, 1'b0);
        else chk("hdr_out", hdr_out, exp_hdr.pop_front());
        hs_cyc = cyc; first_pending = 1'b1; ev_pops = 0;
      end
      if (dout_valid && first_pending) begin
        chk("first_dout_latency", cyc - hs_cyc, 3);
        first_pending = 1'b0;
      end
      got = {dout_last, dout};
      if (dout_valid && held_vld) chk("dout_stable", got, held);
      if (dout_valid && dout_ready) begin
        if (exp_dat.size() == 0) chk("dout_unexpected", 1'b1, 1'b0);
        else begin
          ex = exp_dat.pop_front();
          chk("dout", got, ex);
        end
        if (ev_pops == 0) ev_first_cyc = cyc;
        ev_last_cyc = cyc;
        ev_pops++;
        if (dout_last) last_pop_cyc = cyc;
      end
      held_vld  = dout_valid && !dout_ready;
      held      = got;
      hheld_vld = hdr_valid && !hdr_ready;
      hheld     = hdr_out;
      hv_q      = hdr_valid;
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) bram[i] = '0;
    for (int i = 0; i < 16; i++) hdr_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdreq", hdr_rdreq, 1'b0);   chk("rst_hdr_valid", hdr_valid, 1'b0);
    chk("rst_dout_valid", dout_valid, 1'b0); chk("rst_dout_last", dout_last, 1'b0);
    chk("rst_busy", busy, 1'b0);         chk("rst_eoe_err", eoe_err, 1'b0);
    chk("rst_hdr_out", hdr_out, 87'd0);  chk("rst_dout", dout, 28'd0);
    chk("rst_rd_addr", wvb_rd_addr, 15'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single event, ready high: 4 samples on consecutive cycles
    hdr_ready = 1'b1;
    load_event(15'h0010, 15'h0013, -1, 1);
    en = 1'b1;
    wait_done("t1");
    chk("t1_count", ev_pops, 4);
    chk("t1_burst", ev_last_cyc - ev_first_cyc, 3);
    chk("t1_eoe_err", eoe_err, 1'b0);

    // Wrap-around with delayed header acceptance
    hdr_ready = 1'b0;
    load_event(15'h7FFE, 15'h0001, -1, 2);
    repeat (6) @(negedge clk);
    chk("t2_hold_valid", hdr_valid, 1'b1);
    hdr_ready = 1'b1;
    wait_done("t2");
    chk("t2_count", ev_pops, 4);

    // Random backpressure over 16 samples
    rdy_mode = 1;
    load_event(15'h0100, 15'h010F, -1, 3);
    wait_done("t3");
    chk("t3_count", ev_pops, 16);
    rdy_mode = 0;

    // Empty header FIFO with en high: no pops, stays idle
    repeat (8) begin
      @(negedge clk);
      chk("t4_no_rdreq", hdr_rdreq, 1'b0);
      chk("t4_idle", busy, 1'b0);
    end
    load_event(15'h0200, 15'h0202, -1, 4);
    load_event(15'h0300, 15'h0300, -1, 5);
    wait_done("t4");
    chk("t4_single_count", ev_pops, 1);

    // eoe on the 2nd word only: error latches, last still on 5th
    load_event(15'h0400, 15'h0404, 1, 6);
    wait_done("t5");
    chk("t5_count", ev_pops, 5);
    chk("t5_eoe_err", eoe_err, 1'b1);
    load_event(15'h0410, 15'h0411, -1, 7);
    wait_done("t5b");
    chk("t5_eoe_sticky", eoe_err, 1'b1);

    // Reset mid-stream with the sink stalled
    en = 1'b0;
    rdy_mode = 2;
    load_event(15'h0500, 15'h050F, -1, 8);
    en = 1'b1;
    for (int i = 0; i < 50 && !dout_valid; i++) @(negedge clk);
    chk("t6_streaming", dout_valid, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);          chk("t6_rst_dout_valid", dout_valid, 1'b0);
    chk("t6_rst_dout", dout, 28'd0);         chk("t6_rst_last", dout_last, 1'b0);
    chk("t6_rst_eoe_err", eoe_err, 1'b0);    chk("t6_rst_hdr_out", hdr_out, 87'd0);
    chk("t6_rst_addr", wvb_rd_addr, 15'd0);  chk("t6_rst_rdreq", hdr_rdreq, 1'b0);
    exp_dat.delete();
    exp_hdr.delete();
    en = 1'b0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    load_event(15'h0600, 15'h0602, -1, 9);
    repeat (5) begin
      @(negedge clk);
      chk("t6_idle_rdreq", hdr_rdreq, 1'b0);
      chk("t6_idle_busy", busy, 1'b0);
    end
    en = 1'b1;
    wait_done("t6");
    chk("t6_count", ev_pops, 3);
    chk("t6_eoe_err", eoe_err, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
